// File: rtl/egg_timer_pkg.sv
// Egg timer shared types and constants.
// State encoding, BCD limits and the program-value bundle.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  typedef struct packed {
    logic [3:0] tens_min;
    logic [3:0] min;
    logic [3:0] tens_sec;
    logic [3:0] sec;
  } prog_t;

  function automatic logic prog_nonzero(
    input prog_t p
  );
    return |p;
  endfunction

endpackage

// File: rtl/egg_timer_ctrl_bcd_pair_incr.sv
// Two-digit BCD incrementer with wrap.
// Tens digit wraps to 0 after reaching tens_max.
module bcd_pair_incr
  import egg_timer_pkg::*;
(
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] tens_max,
  output logic [3:0] tens_next,
  output logic [3:0] ones_next
);

  // ones rolls over at 9 and carries into tens, tens wraps at its limit
  always_comb begin
    tens_next = tens;
    ones_next = ones + 4'd1;
    if (ones >= DIGIT_MAX) begin
      ones_next = 4'd0;
      if (tens >= tens_max) begin
        tens_next = 4'd0;
      end else begin
        tens_next = tens + 4'd1;
      end
    end
  end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer control sequencer.
// Programs an MM:SS time, loads/runs time_count, sounds the alarm.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int ALARM_SECONDS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_1s,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       done,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       load,
  output logic       timer_on,
  output logic       alarm,
  output logic [1:0] state
);

  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SECONDS - 1);

  state_t     state_q, state_d;
  logic       paused_q, paused_d;
  prog_t      prog_q, prog_d;
  logic       load_q, load_d;
  logic       on_q, on_d;
  logic       alarm_q, alarm_d;
  logic [5:0] cnt_q, cnt_d;

  logic [3:0] sec_t, sec_o;
  logic [3:0] min_t, min_o;
  logic       any_btn;

  assign any_btn = btn_start | btn_clear | btn_min | btn_sec;

  bcd_pair_incr u_sec_incr (
    .tens      (prog_q.tens_sec),
    .ones      (prog_q.sec),
    .tens_max  (SEC_TENS_MAX),
    .tens_next (sec_t),
    .ones_next (sec_o)
  );

  bcd_pair_incr u_min_incr (
    .tens      (prog_q.tens_min),
    .ones      (prog_q.min),
    .tens_max  (DIGIT_MAX),
    .tens_next (min_t),
    .ones_next (min_o)
  );

  // state, program digits and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_SET;
      paused_q <= 1'b0;
      prog_q   <= '0;
      load_q   <= 1'b0;
      on_q     <= 1'b0;
      alarm_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
      prog_q   <= prog_d;
      load_q   <= load_d;
      on_q     <= on_d;
      alarm_q  <= alarm_d;
      cnt_q    <= cnt_d;
    end
  end

  // next state, digit edits and next output values
  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    prog_d   = prog_q;
    alarm_d  = alarm_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_SET: begin
        priority case (1'b1)
          btn_clear: prog_d = '0;
          btn_start: begin
            if (prog_nonzero(prog_q)) state_d = ST_LOAD;
          end
          btn_min: begin
            prog_d.tens_min = min_t;
            prog_d.min      = min_o;
          end
          btn_sec: begin
            prog_d.tens_sec = sec_t;
            prog_d.sec      = sec_o;
          end
          default: ;
        endcase
      end
      ST_LOAD: begin
        state_d  = ST_RUN;
        paused_d = 1'b0;
      end
      ST_RUN: begin
        if (!paused_q && done) begin
          state_d = ST_ALARM;
          alarm_d = 1'b1;
          cnt_d   = '0;
        end else begin
          priority case (1'b1)
            btn_clear: state_d  = ST_SET;
            btn_start: paused_d = !paused_q;
            default: ;
          endcase
        end
      end
      ST_ALARM: begin
        if (any_btn) begin
          state_d = ST_SET;
        end else if (pulse_1s) begin
          if (cnt_q >= ALARM_LAST) begin
            state_d = ST_SET;
          end else begin
            cnt_d   = cnt_q + 6'd1;
            alarm_d = !alarm_q;
          end
        end
      end
      default: state_d = ST_SET;
    endcase
    if (state_d == ST_SET) begin
      alarm_d  = 1'b0;
      cnt_d    = '0;
      paused_d = 1'b0;
    end
  end

  assign load_d = (state_d == ST_LOAD);
  assign on_d   = (state_d == ST_RUN) && !paused_d;

  assign seconds_prog      = prog_q.sec;
  assign tens_seconds_prog = prog_q.tens_sec;
  assign minutes_prog      = prog_q.min;
  assign tens_minutes_prog = prog_q.tens_min;
  assign load              = load_q;
  assign timer_on          = on_q;
  assign alarm             = alarm_q;
  assign state             = state_q;

endmodule
